// File: rtl/seq_mul_16bit.sv
// Unsigned 16x16 shift-add multiplier: one add-and-shift per cycle through a
// 16-bit carry-lookahead adder, start/busy/done handshake, registered product.

module cla16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);
    logic [15:0] g, p;
    logic [3:0]  gg, gp;
    logic [4:0]  gc;
    logic [16:0] c;

    assign g = x & y;
    assign p = x ^ y;

    // Group generate/propagate per nibble, then group carries, then bit carries.
    always_comb begin
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;
        for (int i = 0; i < 4; i++) begin
            gg[i] = g[4*i+3]
                  | (p[4*i+3] & g[4*i+2])
                  | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                  | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
            gp[i] = &p[4*i +: 4];
        end
        gc[0] = cin;
        for (int i = 0; i < 4; i++)
            gc[i+1] = gg[i] | (gp[i] & gc[i]);
        for (int i = 0; i < 4; i++) begin
            c[4*i] = gc[i];
            for (int j = 0; j < 3; j++)
                c[4*i+j+1] = g[4*i+j] | (p[4*i+j] & c[4*i+j]);
        end
        c[16] = gc[4];
    end

    assign s    = p ^ c[15:0];
    assign cout = c[16];
endmodule

module seq_mul_16bit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e      state_q, state_d;
    logic [15:0] mcand_q, mcand_d;
    logic [15:0] hi_q, hi_d;
    logic [15:0] lo_q, lo_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] product_q, product_d;

    logic [15:0] add_y, sum;
    logic        cout;

    assign add_y = lo_q[0] ? mcand_q : 16'h0000;

    cla16 u_cla (
        .x    (hi_q),
        .y    (add_y),
        .cin  (1'b0),
        .s    (sum),
        .cout (cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    mcand_d = a;
                    hi_d    = 16'h0000;
                    lo_d    = b;
                    cnt_d   = 4'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // 33-bit {cout, sum, lo} shifted right by one; cout lands in hi[15].
                hi_d  = {cout, sum[15:1]};
                lo_d  = {sum[0], lo_q[15:1]};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    product_d = {hi_d, lo_d};
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = product_q;
endmodule
